// File: rtl/board_cond_pkg.sv
// Shared types and constants for the board input conditioner.
package board_cond_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    PRESSED = 2'd2
  } board_state_e;

  typedef logic [1:0] boot_mode_t;

  localparam int unsigned RstCntWidth = 8;

endpackage

// File: rtl/board_debounce.sv
// One-bit synchronizer plus debouncer; pressed_o is 1 when the input sits away from ResetVal.
module board_debounce #(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 50000,
  parameter bit          ResetVal       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic pressed_o
);

  localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

  logic [SyncStages-1:0] sync_d, sync_q;
  logic [CntW-1:0]       cnt_d, cnt_q;
  logic                  pressed_d, pressed_q;
  logic                  level;

  // ResetVal is the idle (not pressed) level, so XOR normalises to pressed=1.
  always_comb begin
    sync_d    = {sync_q[SyncStages-2:0], raw_i};
    level     = sync_q[SyncStages-1] ^ ResetVal;
    cnt_d     = '0;
    pressed_d = pressed_q;
    if (level != pressed_q) begin
      if (cnt_q == CntW'(DebounceCycles - 1)) begin
        pressed_d = ~pressed_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q    <= {SyncStages{ResetVal}};
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed_o = pressed_q;

endmodule

// File: rtl/xilinx_board_input_conditioner.sv
// Board pad conditioning: debounced reset button, stretched SoC reset, boot/test mode latched at release.
// Optional BOARD_COND_RST_CNT_EN adds rst_count_o, a saturating count of button-initiated resets.
module xilinx_board_input_conditioner
  import board_cond_pkg::*;
#(
  parameter int unsigned SyncStages       = 2,
  parameter int unsigned DebounceCycles   = 50000,
  parameter int unsigned HoldCycles       = 1024,
  parameter bit          ButtonActiveHigh = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cpu_reset_i,
  input  logic [1:0]             boot_mode_i,
  input  logic                   test_mode_i,
  output logic                   sys_rst_no,
  output logic [1:0]             boot_mode_o,
  output logic                   test_mode_o,
`ifdef BOARD_COND_RST_CNT_EN
  output logic [RstCntWidth-1:0] rst_count_o,
`endif
  output logic                   btn_pressed_o
);

  localparam int unsigned HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam int unsigned SwW   = 3;

  board_state_e                    state_d, state_q;
  logic [HoldW-1:0]                hold_cnt_d, hold_cnt_q;
  logic                            sys_rst_d, sys_rst_q;
  boot_mode_t                      boot_mode_d, boot_mode_q;
  logic                            test_mode_d, test_mode_q;
  logic [SyncStages-1:0][SwW-1:0]  sw_sync_d, sw_sync_q;
  logic [SwW-1:0]                  sw_synced;

  board_debounce #(
    .SyncStages     (SyncStages),
    .DebounceCycles (DebounceCycles),
    .ResetVal       (!ButtonActiveHigh)
  ) u_btn_debounce (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .raw_i     (cpu_reset_i),
    .pressed_o (btn_pressed_o)
  );

  // Switch synchronizer chains; bit 2 is test mode, bits 1:0 boot mode.
  always_comb begin
    sw_sync_d    = sw_sync_q;
    sw_sync_d[0] = {test_mode_i, boot_mode_i};
    for (int unsigned i = 1; i < SyncStages; i++) begin
      sw_sync_d[i] = sw_sync_q[i-1];
    end
    sw_synced = sw_sync_q[SyncStages-1];
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    sys_rst_d   = 1'b0;
    boot_mode_d = boot_mode_q;
    test_mode_d = test_mode_q;
    case (state_q)
      HOLD: begin
        hold_cnt_d = hold_cnt_q + HoldW'(1);
        if (btn_pressed_o) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldW'(HoldCycles - 1)) begin
          state_d     = RUN;
          hold_cnt_d  = '0;
          sys_rst_d   = 1'b1;
          boot_mode_d = boot_mode_t'(sw_synced[1:0]);
          test_mode_d = sw_synced[2];
        end
      end
      RUN: begin
        sys_rst_d = 1'b1;
        if (btn_pressed_o) begin
          state_d   = PRESSED;
          sys_rst_d = 1'b0;
        end
      end
      PRESSED: begin
        if (!btn_pressed_o) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = HOLD;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      sys_rst_q   <= 1'b0;
      boot_mode_q <= '0;
      test_mode_q <= 1'b0;
      sw_sync_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      sys_rst_q   <= sys_rst_d;
      boot_mode_q <= boot_mode_d;
      test_mode_q <= test_mode_d;
      sw_sync_q   <= sw_sync_d;
    end
  end

  assign sys_rst_no  = sys_rst_q;
  assign boot_mode_o = boot_mode_q;
  assign test_mode_o = test_mode_q;

`ifdef BOARD_COND_RST_CNT_EN
  logic [RstCntWidth-1:0] rst_cnt_d, rst_cnt_q;

  // Counts RUN->PRESSED transitions only; survives button resets, saturates.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if ((state_q == RUN) && btn_pressed_o && (rst_cnt_q != '1)) begin
      rst_cnt_d = rst_cnt_q + RstCntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rst_cnt_q <= '0;
    end else begin
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign rst_count_o = rst_cnt_q;
`endif

endmodule
